dispense_scheduler: RTL
=======================

Name: dispense_scheduler

Overview:
- Sequences one shared dispenser motor driver across NUM_COMP pill compartments.
- Consumes the single-cycle time-slot pulses (morning/afternoon/evening) from the dispense-time logic and the per-compartment slot masks from the dispense setter.
- Drives the compartments' motor one at a time with fixed on/gap timing, so two compartments never run concurrently.
- Queues slot events that arrive while a previous slot is still being serviced.

Parameters:
- NUM_COMP, 2, number of compartments sharing the motor driver (1..8).
- PULSE_CYCLES, 25000000, clock cycles motor_on is held per dispense (0.5 s at 50 MHz); must be >= 1.
- GAP_CYCLES, 25000000, idle cycles after each dispense before the next compartment; must be >= 1.
- RETRY_MAX, 2, retries per compartment (used only with DISPENSE_CONFIRM_EN).

Ports:
- clock  in  1  system clock (50 MHz).
- resetn  in  1  asynchronous active-low reset.
- morning_p  in  1  one-cycle slot pulse, slot 0.
- afternoon_p  in  1  one-cycle slot pulse, slot 1.
- evening_p  in  1  one-cycle slot pulse, slot 2.
- comp_cfg  in  3*NUM_COMP  per-compartment slot mask; bits [3i+2:3i] = {evening, afternoon, morning} for compartment i.
- hold  in  1  clock-set mode; blocks the start of new slots.
- drop_sense  in  1  pill-drop sensor, active high (DISPENSE_CONFIRM_EN only).
- motor_sel  out  NUM_COMP  one-hot compartment select.
- motor_on  out  1  motor drive enable.
- busy  out  1  high whenever the FSM is not in IDLE.
- active_slot  out  2  slot being serviced (0/1/2); 3 when idle.
- slot_done_p  out  1  one-cycle pulse when a slot finishes.
- dispense_count  out  8  total dispenses issued; saturates at 255.
- fault  out  1  sticky confirm failure (DISPENSE_CONFIRM_EN only).

Behaviour:
- Reset: resetn low asynchronously forces every output and internal register to reset state:
  - FSM=IDLE, pend=000, motor_sel=0, motor_on=0, busy=0, active_slot=3, slot_done_p=0, dispense_count=0, fault=0.
  - Reset mid-drive drops motor_on in the same cycle and discards all pending slots.
- pend[2:0] handling:
  - A slot pulse sets its pend bit at the sampling edge.
  - A pulse for an already-pending slot merges with it and is not duplicated.
  - A pulse for the slot currently being serviced is dropped.
  - Simultaneous pulses set multiple bits.
- IDLE:
  - If hold=0 and pend!=0: latch the lowest-index pending slot (morning > afternoon > evening), set idx=0, go to SCAN.
  - If hold=1, remain in IDLE; pulses are still latched.
- SCAN (one compartment per cycle):
  - If comp_cfg[3*idx+slot]=1: motor_sel=onehot(idx), motor_on=1, load timer, go to DRIVE.
  - Else if idx=NUM_COMP-1: clear pend[slot], pulse slot_done_p, go to IDLE.
  - Else idx++.
  - comp_cfg is sampled live at each SCAN cycle; changes during DRIVE/GAP take effect for later compartments only.
- DRIVE:
  - motor_on stays high for exactly PULSE_CYCLES cycles.
  - Then motor_on=0, motor_sel=0, dispense_count increments (saturating), go to GAP.
- GAP:
  - Waits GAP_CYCLES cycles.
  - If idx=NUM_COMP-1: finish the slot as in SCAN.
  - Else idx++ and return to SCAN.
- hold asserted mid-slot does not abort; the current slot completes.
- Latency: pulse sampled at edge k; SCAN after edge k+1; motor_on high after edge k+2 when compartment 0 is enabled.
- busy = (state != IDLE). active_slot is valid from SCAN entry through slot_done_p.
- A slot whose mask is empty for all compartments completes in NUM_COMP SCAN cycles with no motor activity, and still pulses slot_done_p.

Optional Feature:
- Macro: DISPENSE_CONFIRM_EN.
- When defined, a CONFIRM state follows GAP:
  - A drop_sense high at any cycle during DRIVE or GAP counts as confirmed.
  - If not confirmed and retries < RETRY_MAX: retry the same compartment (back to DRIVE; dispense_count increments again).
  - After RETRY_MAX failed retries: set sticky fault, cleared only by reset, and move to the next compartment.
- When undefined: drop_sense is ignored, fault is tied to 0, and there is no CONFIRM state.

Test Plan:
- All bench runs use PULSE_CYCLES=4, GAP_CYCLES=2.
- Reset: hold resetn low 3 cycles -> all outputs at reset values, active_slot=3.
- Single slot: comp_cfg=6'b001_001, morning_p pulse -> motor_sel=01 for 4 cycles, 2-cycle gap, then motor_sel=10 for 4 cycles; dispense_count=2; one slot_done_p.
- Queueing: evening_p and morning_p in the same cycle, comp_cfg=6'b100_001 -> morning services compartment 0 first, then evening services compartment 1; two slot_done_p pulses; pend=000 at end.
- Merge/drop: morning_p pulsed twice while morning is active -> serviced once; dispense_count=2, not 4.
- Hold and reset: hold=1, afternoon_p -> no motor activity, busy=0; release hold -> slot runs. Assert resetn low mid-DRIVE -> motor_on=0 in the same cycle, pend cleared.
- DISPENSE_CONFIRM_EN: drop_sense held 0 -> compartment 0 driven 3 times (1 + RETRY_MAX), fault=1, scheduler proceeds to compartment 1.

Source files
------------

// File: rtl/dispense_scheduler.sv
// Time-shares one dispenser motor driver across NUM_COMP compartments and services queued slots.
// Define DISPENSE_CONFIRM_EN to add pill-drop confirmation with per-compartment retries and a sticky fault.
module dispense_scheduler #(
    parameter int NUM_COMP     = 2,
    parameter int PULSE_CYCLES = 25000000,
    parameter int GAP_CYCLES   = 25000000,
    parameter int RETRY_MAX    = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  morning_p,
    input  logic                  afternoon_p,
    input  logic                  evening_p,
    input  logic [3*NUM_COMP-1:0] comp_cfg,
    input  logic                  hold,
    input  logic                  drop_sense,
    output logic [NUM_COMP-1:0]   motor_sel,
    output logic                  motor_on,
    output logic                  busy,
    output logic [1:0]            active_slot,
    output logic                  slot_done_p,
    output logic [7:0]            dispense_count,
    output logic                  fault,
    output logic [2:0]            fsm_state,
    output logic [2:0]            pend_state
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SCAN  = 3'd1;
    localparam logic [2:0] ST_DRIVE = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
`ifdef DISPENSE_CONFIRM_EN
    localparam logic [2:0] ST_CONFIRM = 3'd4;
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
`endif

    localparam int IW   = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1;
    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_COMP - 1);

    logic [2:0]          state;
    logic [2:0]          pend;
    logic [1:0]          slot;
    logic [IW-1:0]       idx;
    logic [TW-1:0]       timer;

    logic [2:0]          slot_mask;
    logic [2:0]          pend_merged;
    logic [1:0]          first_slot;
    logic                cfg_hit;
    logic                last_comp;
    logic [NUM_COMP-1:0] idx_onehot;

`ifdef DISPENSE_CONFIRM_EN
    logic                confirmed;
    logic [RW-1:0]       retries;
`else
    logic                unused_cfg;
    assign unused_cfg = drop_sense & (RETRY_MAX > 0);
    assign fault      = 1'b0;
`endif

    // Pulses for the slot in service are dropped; pulses for pending slots merge.
    always_comb begin
        slot_mask   = (state != ST_IDLE) ? (3'b001 << slot) : 3'b000;
        pend_merged = pend | ({evening_p, afternoon_p, morning_p} & ~slot_mask);
        first_slot  = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);
        cfg_hit     = comp_cfg[3*int'(idx) + int'(slot)];
        last_comp   = (idx == LAST_IDX);
        idx_onehot  = NUM_COMP'(1) << idx;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            pend           <= 3'b000;
            slot           <= 2'd0;
            idx            <= '0;
            timer          <= '0;
            motor_sel      <= '0;
            motor_on       <= 1'b0;
            slot_done_p    <= 1'b0;
            dispense_count <= 8'd0;
`ifdef DISPENSE_CONFIRM_EN
            confirmed      <= 1'b0;
            retries        <= '0;
            fault          <= 1'b0;
`endif
        end else begin
            slot_done_p <= 1'b0;
            pend        <= pend_merged;
            case (state)
                ST_IDLE: begin
                    if (!hold && pend != 3'b000) begin
                        slot  <= first_slot;
                        idx   <= '0;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (cfg_hit) begin
                        motor_sel <= idx_onehot;
                        motor_on  <= 1'b1;
                        timer     <= PULSE_LOAD;
                        state     <= ST_DRIVE;
`ifdef DISPENSE_CONFIRM_EN
                        confirmed <= 1'b0;
`endif
                    end else if (last_comp) begin
                        pend        <= pend_merged & ~(3'b001 << slot);
                        slot_done_p <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DRIVE: begin
`ifdef DISPENSE_CONFIRM_EN
                    if (drop_sense) confirmed <= 1'b1;
`endif
                    if (timer == '0) begin
                        motor_on  <= 1'b0;
                        motor_sel <= '0;
                        if (dispense_count != 8'hFF) dispense_count <= dispense_count + 8'd1;
                        timer     <= GAP_LOAD;
                        state     <= ST_GAP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_GAP: begin
`ifdef DISPENSE_CONFIRM_EN
                    if (drop_sense) confirmed <= 1'b1;
                    if (timer == '0) begin
                        state <= ST_CONFIRM;
                    end else begin
                        timer <= timer - 1'b1;
                    end
`else
                    if (timer == '0) begin
                        if (last_comp) begin
                            pend        <= pend_merged & ~(3'b001 << slot);
                            slot_done_p <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_SCAN;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
`endif
                end
`ifdef DISPENSE_CONFIRM_EN
                ST_CONFIRM: begin
                    if (!confirmed && retries < RW'(RETRY_MAX)) begin
                        // Re-drive the same compartment; the retry counts as another dispense.
                        retries   <= retries + 1'b1;
                        motor_sel <= idx_onehot;
                        motor_on  <= 1'b1;
                        timer     <= PULSE_LOAD;
                        confirmed <= 1'b0;
                        state     <= ST_DRIVE;
                    end else begin
                        if (!confirmed) fault <= 1'b1;
                        retries <= '0;
                        if (last_comp) begin
                            pend        <= pend_merged & ~(3'b001 << slot);
                            slot_done_p <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_SCAN;
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state != ST_IDLE);
    assign active_slot = (busy || slot_done_p) ? slot : 2'd3;
    assign fsm_state   = state;
    assign pend_state  = pend;

endmodule
